// File: rtl/timer_pkg.sv
// Shared register map, CTRL field layout and helpers for the multi-channel timer.
package timer_pkg;

    localparam int unsigned APB_AW = 12;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_SW = APB_DW / 8;

    localparam logic [3:0] OFS_CTRL = 4'h0;
    localparam logic [3:0] OFS_CMP  = 4'h4;
    localparam logic [3:0] OFS_CNT  = 4'h8;
    localparam logic [3:0] OFS_STAT = 4'hC;

    localparam logic [APB_AW-1:0] ADDR_INT_STAT = 12'h100;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_DIV_EN   = 1;
    localparam int unsigned CTRL_DIV_LSB  = 4;
    localparam int unsigned CTRL_DIV_MSB  = 7;
    localparam int unsigned CTRL_MODE     = 8;
    localparam int unsigned CTRL_INT_EN   = 9;
    localparam int unsigned CTRL_DBG_HALT = 10;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    typedef struct packed {
        logic       dbg_halt;
        logic       int_en;
        mode_e      mode;
        logic [3:0] div_val;
        logic       div_en;
        logic       en;
    } ctrl_t;

    // CTRL register image; reserved bits read as zero.
    function automatic logic [APB_DW-1:0] ctrl_to_word(input ctrl_t c);
        logic [APB_DW-1:0] w;
        w = '0;
        w[CTRL_EN]                   = c.en;
        w[CTRL_DIV_EN]               = c.div_en;
        w[CTRL_DIV_MSB:CTRL_DIV_LSB] = c.div_val;
        w[CTRL_MODE]                 = c.mode;
        w[CTRL_INT_EN]               = c.int_en;
        w[CTRL_DBG_HALT]             = c.dbg_halt;
        return w;
    endfunction

    function automatic logic [APB_DW-1:0] merge_bytes(input logic [APB_DW-1:0] old,
                                                      input logic [APB_DW-1:0] wdata,
                                                      input logic [APB_SW-1:0] strb);
        logic [APB_DW-1:0] r;
        r = old;
        for (int i = 0; i < int'(APB_SW); i++) begin
            if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_mch_if.sv
// APB slave bus of the multi-channel timer.
interface timer_mch_if;
    import timer_pkg::*;

    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [APB_AW-1:0] tim_paddr;
    logic [APB_DW-1:0] tim_pwdata;
    logic [APB_SW-1:0] tim_pstrb;
    logic [APB_DW-1:0] tim_prdata;
    logic              tim_pready;
    logic              tim_pslverr;

    modport master (
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_prdata, tim_pready, tim_pslverr
    );

    modport slave (
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_prdata, tim_pready, tim_pslverr
    );

endinterface

// File: rtl/timer_chan.sv
// One timer channel: prescaler, counter, compare, sticky match flag.
module timer_chan
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_mode,
    input  logic              wr_ctrl,
    input  logic              wr_cmp,
    input  logic              wr_cnt,
    input  logic              wr_stat,
    input  logic [APB_DW-1:0] wdata,
    input  logic [APB_SW-1:0] strb,
    output ctrl_t             ctrl,
    output logic [CNT_W-1:0]  cmp,
    output logic [CNT_W-1:0]  cnt,
    output logic              flag,
    output logic              irq_c
);

    logic [3:0]        presc;
    logic [3:0]        presc_nxt;
    ctrl_t             ctrl_nxt;
    logic [CNT_W-1:0]  cmp_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              flag_nxt;
    logic [APB_DW-1:0] ctrl_w;
    logic [APB_DW-1:0] cmp_w;
    logic [APB_DW-1:0] cnt_w;
    logic              active;
    logic              tick;
    logic              unused_wbits;

    assign ctrl_w       = merge_bytes(ctrl_to_word(ctrl), wdata, strb);
    assign cmp_w        = merge_bytes(APB_DW'(cmp), wdata, strb);
    assign cnt_w        = merge_bytes(APB_DW'(cnt), wdata, strb);
    assign unused_wbits = ^{ctrl_w, cmp_w, cnt_w};

    assign active = ctrl.en & ~(dbg_mode & ctrl.dbg_halt);
    assign tick   = active & (~ctrl.div_en | (presc >= ctrl.div_val));
    assign irq_c  = flag & ctrl.int_en;

    // Software CNT write beats the tick; a match beats a same-cycle W1C.
    always_comb begin
        ctrl_nxt  = ctrl;
        cmp_nxt   = cmp;
        cnt_nxt   = cnt;
        presc_nxt = presc;
        flag_nxt  = flag;

        if (wr_ctrl) begin
            ctrl_nxt.en       = ctrl_w[CTRL_EN];
            ctrl_nxt.div_en   = ctrl_w[CTRL_DIV_EN];
            ctrl_nxt.div_val  = ctrl_w[CTRL_DIV_MSB:CTRL_DIV_LSB];
            ctrl_nxt.mode     = mode_e'(ctrl_w[CTRL_MODE]);
            ctrl_nxt.int_en   = ctrl_w[CTRL_INT_EN];
            ctrl_nxt.dbg_halt = ctrl_w[CTRL_DBG_HALT];
        end
        if (wr_cmp) cmp_nxt = CNT_W'(cmp_w);
        if (wr_stat && strb[0] && wdata[0]) flag_nxt = 1'b0;

        if (wr_cnt) begin
            cnt_nxt   = CNT_W'(cnt_w);
            presc_nxt = '0;
        end else if (active) begin
            if (ctrl.div_en) presc_nxt = tick ? 4'd0 : presc + 4'd1;
            if (tick) begin
                if (cnt == cmp) begin
                    cnt_nxt  = '0;
                    flag_nxt = 1'b1;
                    if (ctrl.mode == MODE_ONESHOT) ctrl_nxt.en = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end

        // A stopped or undivided channel restarts with a full prescaler period.
        if (!ctrl_nxt.en || !ctrl_nxt.div_en) presc_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            cmp   <= '0;
            cnt   <= '0;
            presc <= '0;
            flag  <= 1'b0;
        end else begin
            ctrl  <= ctrl_nxt;
            cmp   <= cmp_nxt;
            cnt   <= cnt_nxt;
            presc <= presc_nxt;
            flag  <= flag_nxt;
        end
    end

endmodule

// File: rtl/timer_mch.sv
// Multi-channel APB timer: address decode, read mux, registered interrupts.
module timer_mch
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    timer_mch_if.slave        apb,
    input  logic              dbg_mode,
    output logic [NUM_CH-1:0] tim_int,
    output logic              tim_int_any
);

    logic              access;
    logic              hit_chan;
    logic              hit_int;
    logic              err;
    logic              wr_ok;
    logic              rd_ok;
    logic [3:0]        ch_idx;
    logic [3:0]        offs;
    logic [APB_DW-1:0] rdata;

    ctrl_t             ch_ctrl [NUM_CH];
    logic [CNT_W-1:0]  ch_cmp  [NUM_CH];
    logic [CNT_W-1:0]  ch_cnt  [NUM_CH];
    logic [NUM_CH-1:0] flags;
    logic [NUM_CH-1:0] irq_c;

    assign ch_idx   = apb.tim_paddr[7:4];
    assign offs     = apb.tim_paddr[3:0];
    assign access   = apb.tim_psel & apb.tim_penable;
    assign hit_int  = (apb.tim_paddr == ADDR_INT_STAT);
    assign hit_chan = (apb.tim_paddr[11:8] == 4'h0) && ({28'h0, ch_idx} < NUM_CH)
                      && (apb.tim_paddr[1:0] == 2'b00);
    assign err      = access & ~(hit_chan | (hit_int & ~apb.tim_pwrite));
    assign wr_ok    = access & apb.tim_pwrite & hit_chan;
    assign rd_ok    = access & ~apb.tim_pwrite & (hit_chan | hit_int) & ~sys_rst;

    assign apb.tim_pready  = apb.tim_psel;
    assign apb.tim_pslverr = err & ~sys_rst;
    assign apb.tim_prdata  = rdata;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        logic sel;
        assign sel = wr_ok && (ch_idx == 4'(n));

        timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .dbg_mode (dbg_mode),
            .wr_ctrl  (sel && (offs == OFS_CTRL)),
            .wr_cmp   (sel && (offs == OFS_CMP)),
            .wr_cnt   (sel && (offs == OFS_CNT)),
            .wr_stat  (sel && (offs == OFS_STAT)),
            .wdata    (apb.tim_pwdata),
            .strb     (apb.tim_pstrb),
            .ctrl     (ch_ctrl[n]),
            .cmp      (ch_cmp[n]),
            .cnt      (ch_cnt[n]),
            .flag     (flags[n]),
            .irq_c    (irq_c[n])
        );
    end

    always_comb begin
        rdata = '0;
        if (rd_ok) begin
            if (hit_int) begin
                rdata = APB_DW'(flags);
            end else begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (ch_idx == 4'(n)) begin
                        case (offs)
                            OFS_CTRL: rdata = ctrl_to_word(ch_ctrl[n]);
                            OFS_CMP:  rdata = APB_DW'(ch_cmp[n]);
                            OFS_CNT:  rdata = APB_DW'(ch_cnt[n]);
                            OFS_STAT: rdata = APB_DW'(flags[n]);
                            default:  rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tim_int     <= '0;
            tim_int_any <= 1'b0;
        end else begin
            tim_int     <= irq_c;
            tim_int_any <= |irq_c;
        end
    end

endmodule

// File: tb/tb_timer_mch.sv
// Directed bench for timer_mch: a 4x32 instance and a 1x8 instance for wrap tests.
module tb_timer_mch;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg;
    logic [3:0]  int_a;
    logic        any_a;
    logic [0:0]  int_b;
    logic        any_b;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        wr_err;
    int          checks   = 0;
    int          failures = 0;

    timer_mch_if bus_a ();
    timer_mch_if bus_b ();

    timer_mch #(.NUM_CH(4), .CNT_W(32)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .apb(bus_a.slave), .dbg_mode(dbg),
        .tim_int(int_a), .tim_int_any(any_a)
    );

    timer_mch #(.NUM_CH(1), .CNT_W(8)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .apb(bus_b.slave), .dbg_mode(dbg),
        .tim_int(int_b), .tim_int_any(any_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit u, input logic sel, input logic en, input logic wr,
                         input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!u) begin
            bus_a.tim_psel = sel; bus_a.tim_penable = en; bus_a.tim_pwrite = wr;
            bus_a.tim_paddr = a; bus_a.tim_pwdata = d; bus_a.tim_pstrb = s;
        end else begin
            bus_b.tim_psel = sel; bus_b.tim_penable = en; bus_b.tim_pwrite = wr;
            bus_b.tim_paddr = a; bus_b.tim_pwdata = d; bus_b.tim_pstrb = s;
        end
    endtask

    // Setup phase now, access phase from the next negedge; commits at the posedge after that.
    task automatic apb_wr(input bit u, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        drive(u, 1'b1, 1'b0, 1'b1, a, d, s);
        @(negedge clk);
        drive(u, 1'b1, 1'b1, 1'b1, a, d, s);
        #1;
        wr_err = u ? bus_b.tim_pslverr : bus_a.tim_pslverr;
        @(negedge clk);
        drive(u, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    // Zero-cycle access-phase read in the low clock phase; no edge passes.
    task automatic rd_now(input bit u, input logic [11:0] a);
        drive(u, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
        #1;
        rd_data = u ? bus_b.tim_prdata : bus_a.tim_prdata;
        rd_err  = u ? bus_b.tim_pslverr : bus_a.tim_pslverr;
        drive(u, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    task automatic chk_rd(input bit u, input logic [11:0] a, input logic [31:0] exp,
                          input string tag);
        rd_now(u, a);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1;
        dbg = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);

        // Reset state
        rd_now(0, 12'h0F0);
        chk("rst_prdata", rd_data, 32'h0);
        chk("rst_pslverr", 32'(rd_err), 32'h0);
        chk("rst_int", 32'(int_a), 32'h0);
        chk("rst_any", 32'(any_a), 32'h0);
        rst = 1'b0;
        chk_rd(0, 12'h000, 32'h0, "rst_ctrl0");
        chk_rd(0, 12'h008, 32'h0, "rst_cnt0");
        drive(0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1 chk("pready_sel", 32'(bus_a.tim_pready), 32'h1);
        drive(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1 chk("pready_idle", 32'(bus_a.tim_pready), 32'h0);
        @(negedge clk);

        // Periodic ch0: CMP=4 gives CNT 0..4,0 and a flag every 5 ticks
        apb_wr(0, 12'h004, 32'd4, 4'hF);
        chk("cmp_wr_err", 32'(wr_err), 32'h0);
        apb_wr(0, 12'h000, 32'h201, 4'hF);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            chk_rd(0, 12'h008, 32'(k % 5), "per_cnt");
            chk_rd(0, 12'h00C, (k >= 5) ? 32'h1 : 32'h0, "per_stat");
            chk("per_int", 32'(int_a), (k >= 6) ? 32'h1 : 32'h0);
            chk("per_any", 32'(any_a), (k >= 6) ? 32'h1 : 32'h0);
        end
        apb_wr(0, 12'h00C, 32'h1, 4'h1);
        chk_rd(0, 12'h00C, 32'h0, "w1c_clear");
        chk("w1c_int_lag", 32'(int_a[0]), 32'h1);
        @(negedge clk);
        chk("w1c_int_drop", 32'(int_a[0]), 32'h0);
        apb_wr(0, 12'h00C, 32'h1, 4'h1);
        chk_rd(0, 12'h00C, 32'h1, "w1c_race_set_wins");
        chk_rd(0, 12'h008, 32'h0, "w1c_race_cnt");
        apb_wr(0, 12'h000, 32'h0, 4'hF);
        chk_rd(0, 12'h008, 32'h2, "dis_cnt");
        repeat (3) @(negedge clk);
        chk_rd(0, 12'h008, 32'h2, "dis_cnt_hold");

        // Prescaled one-shot ch1: DIV_VAL=3, CMP=2 -> flag after 12 cycles
        apb_wr(0, 12'h014, 32'd2, 4'hF);
        apb_wr(0, 12'h010, 32'h133, 4'hF);
        repeat (11) @(negedge clk);
        chk_rd(0, 12'h01C, 32'h0, "os_stat_pre");
        chk_rd(0, 12'h018, 32'h2, "os_cnt_pre");
        chk_rd(0, 12'h010, 32'h133, "os_ctrl_pre");
        @(negedge clk);
        chk_rd(0, 12'h01C, 32'h1, "os_stat");
        chk_rd(0, 12'h010, 32'h132, "os_en_clear");
        chk_rd(0, 12'h018, 32'h0, "os_cnt");
        repeat (8) @(negedge clk);
        chk_rd(0, 12'h018, 32'h0, "os_cnt_hold");
        chk("os_no_int", 32'(int_a[1]), 32'h0);
        chk_rd(0, 12'h100, 32'h3, "int_stat");

        // Byte strobes, reserved bits and error responses on ch2
        apb_wr(0, 12'h024, 32'hFFFF_FFFF, 4'h1);
        chk_rd(0, 12'h024, 32'h0000_00FF, "strb_b0");
        apb_wr(0, 12'h024, 32'hAABB_CCDD, 4'h4);
        chk_rd(0, 12'h024, 32'h00BB_00FF, "strb_b2");
        apb_wr(0, 12'h025, 32'h1234_5678, 4'hF);
        chk("unalign_err", 32'(wr_err), 32'h1);
        chk_rd(0, 12'h024, 32'h00BB_00FF, "unalign_noeffect");
        rd_now(0, 12'h0F0);
        chk("oor_err", 32'(rd_err), 32'h1);
        chk("oor_data", rd_data, 32'h0);
        rd_now(0, 12'h040);
        chk("ch4_err", 32'(rd_err), 32'h1);
        apb_wr(0, 12'h100, 32'h0, 4'hF);
        chk("intstat_wr_err", 32'(wr_err), 32'h1);
        chk_rd(0, 12'h100, 32'h3, "intstat_unchanged");
        apb_wr(0, 12'h020, 32'hFFFF_F8F0, 4'hF);
        chk_rd(0, 12'h020, 32'h0000_00F0, "ctrl_reserved");

        // Debug halt: ch3 halts, ch0 (DBG_HALT=0) keeps counting
        apb_wr(0, 12'h008, 32'h0, 4'hF);
        apb_wr(0, 12'h004, 32'd1000, 4'hF);
        apb_wr(0, 12'h034, 32'd1000, 4'hF);
        apb_wr(0, 12'h000, 32'h001, 4'hF);
        apb_wr(0, 12'h030, 32'h401, 4'hF);
        chk_rd(0, 12'h008, 32'd2, "dbg_ch0_start");
        chk_rd(0, 12'h038, 32'd0, "dbg_ch3_start");
        repeat (3) @(negedge clk);
        chk_rd(0, 12'h038, 32'd3, "dbg_ch3_pre");
        dbg = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk_rd(0, 12'h038, 32'd3, "dbg_ch3_frozen");
            chk_rd(0, 12'h008, 32'(5 + i), "dbg_ch0_runs");
        end
        dbg = 1'b0;
        @(negedge clk);
        chk_rd(0, 12'h038, 32'd4, "dbg_ch3_resume");
        chk_rd(0, 12'h008, 32'd16, "dbg_ch0_after");

        // 8-bit instance: width masking, wrap through 0xFF, match at 0x10
        rd_now(1, 12'h010);
        chk("b_ch1_err", 32'(rd_err), 32'h1);
        apb_wr(1, 12'h004, 32'h1234_5610, 4'hF);
        chk_rd(1, 12'h004, 32'h10, "b_cmp_mask");
        apb_wr(1, 12'h008, 32'hABCD_0020, 4'hF);
        chk_rd(1, 12'h008, 32'h20, "b_cnt_mask");
        apb_wr(1, 12'h000, 32'h201, 4'hF);
        chk_rd(1, 12'h008, 32'h20, "b_cnt_start");
        repeat (223) @(negedge clk);
        chk_rd(1, 12'h008, 32'hFF, "b_cnt_max");
        @(negedge clk);
        chk_rd(1, 12'h008, 32'h00, "b_wrap");
        chk_rd(1, 12'h00C, 32'h0, "b_wrap_noflag");
        repeat (16) @(negedge clk);
        chk_rd(1, 12'h008, 32'h10, "b_at_cmp");
        chk_rd(1, 12'h00C, 32'h0, "b_stat_pre");
        @(negedge clk);
        chk_rd(1, 12'h008, 32'h0, "b_match_cnt");
        chk_rd(1, 12'h00C, 32'h1, "b_match_stat");
        chk("b_int_pre", 32'(int_b), 32'h0);
        @(negedge clk);
        chk("b_int", 32'(int_b), 32'h1);
        chk("b_any", 32'(any_b), 32'h1);

        // Reset on the edge of an in-flight match
        apb_wr(1, 12'h00C, 32'h1, 4'h1);
        chk_rd(1, 12'h00C, 32'h0, "b_clear");
        repeat (13) @(negedge clk);
        chk_rd(1, 12'h008, 32'h10, "b_pre_rst");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_b_int", 32'(int_b), 32'h0);
        chk("rst_b_any", 32'(any_b), 32'h0);
        rst = 1'b0;
        chk_rd(1, 12'h00C, 32'h0, "rst_b_stat");
        chk_rd(1, 12'h008, 32'h0, "rst_b_cnt");
        chk_rd(1, 12'h000, 32'h0, "rst_b_ctrl");
        chk_rd(1, 12'h004, 32'h0, "rst_b_cmp");
        chk_rd(0, 12'h030, 32'h0, "rst_a_ctrl3");
        chk_rd(0, 12'h100, 32'h0, "rst_a_intstat");
        @(negedge clk);
        chk("rst_b_int_after", 32'(int_b), 32'h0);
        chk_rd(1, 12'h008, 32'h0, "rst_b_cnt_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_mch.md
TIMER_MCH -- requirements
Module: timer_mch

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 Parameter CNT_W, default 32, counter/compare width in bits (legal 8..32).
REQ-003 sys_clk  input  1  single clock; all logic rising-edge.
REQ-004 sys_rst  input  1  reset, synchronous and active-high.
REQ-005 tim_psel, tim_penable, tim_pwrite  input  1 each  APB control.
REQ-006 tim_paddr  input  12  byte address; tim_pwdata  input  32; tim_pstrb  input  4  byte write enables.
REQ-007 tim_prdata  output  32; tim_pready  output  1; tim_pslverr  output  1.
REQ-008 dbg_mode  input  1  debug halt request.
REQ-009 tim_int  output  NUM_CH  per-channel interrupt; tim_int_any  output  1  OR of tim_int.

Function
REQ-010 APB zero-wait: tim_pready SHALL be 1 whenever tim_psel is 1; writes commit at the access-phase edge (psel&penable&pwrite); tim_prdata SHALL be valid combinationally during the access phase, 0 otherwise.
REQ-011 Channel n base = n*0x10: +0x0 CTRL, +0x4 CMP, +0x8 CNT, +0xC STAT; 0x100 INT_STAT (RO, bit n = channel n flag).
REQ-012 CTRL fields: [0] EN, [1] DIV_EN, [7:4] DIV_VAL, [8] MODE (0 periodic, 1 one-shot), [9] INT_EN, [10] DBG_HALT; other bits read 0.
REQ-013 Writes SHALL honour tim_pstrb per byte; bytes with strobe 0 unchanged; bits above CNT_W in CMP/CNT ignored and read 0.
REQ-014 tim_pslverr SHALL be 1 in the access phase for addresses outside the map, channels >= NUM_CH, writes to INT_STAT, or unaligned addresses; such writes have no effect.
REQ-015 Tick: with EN=1 and DIV_EN=0 every cycle; with DIV_EN=1 one cycle in every DIV_VAL+1 cycles via per-channel prescaler.
REQ-016 Counting SHALL be suppressed (counter and prescaler hold) while dbg_mode=1 and DBG_HALT=1.
REQ-017 On a tick, if CNT == CMP: set STAT[0], CNT <= 0; if MODE=1 also clear EN; else CNT <= CNT+1, wrapping from 2^CNT_W-1 to 0 without setting the flag.
REQ-018 CMP=0 SHALL produce a match on every tick.
REQ-019 STAT[0] SHALL clear on write of 1 (W1C); simultaneous hardware set and software clear: set wins.
REQ-020 Software write to CNT SHALL override the tick update in that cycle and reset the prescaler.
REQ-021 EN 1->0 SHALL hold CNT and reset the prescaler; EN 0->1 starts with a full prescaler period.
REQ-022 tim_int[n] SHALL be registered: STAT[0] & INT_EN, asserting one cycle after the flag sets; tim_int_any registered likewise.

Reset
REQ-023 On sys_rst=1: all CTRL, CMP, CNT, STAT, prescalers, tim_int, tim_int_any = 0; tim_prdata = 0, tim_pslverr = 0.
REQ-024 Reset mid-count SHALL abort counting at the next edge; no interrupt SHALL be produced by an in-flight match.

Structure
REQ-025 Shared package timer_pkg SHALL hold register offsets, CTRL field bit positions, MODE encoding and the INT_STAT address.
REQ-026 Sub-module timer_chan (prescaler, counter, compare, flag) SHALL be instantiated NUM_CH times via generate; timer_mch holds APB decode and read mux.
REQ-027 Implementation 120-400 RTL lines total; no latches, no multicycle paths.

Verification
REQ-028 Periodic: CMP=4, DIV_EN=0, INT_EN=1, EN=1 -> flag every 5 cycles, tim_int[0] rises 1 cycle after flag, CNT sequence 0..4,0.
REQ-029 Prescale one-shot: DIV_VAL=3, MODE=1, CMP=2 -> flag after 12 cycles, EN reads 0, CNT holds 0.
REQ-030 W1C race: STAT write 0x1 in the same cycle as a match -> STAT[0] reads 1.
REQ-031 Strobes/errors: write 0xFFFF_FFFF to CMP with pstrb=0x1 -> CMP=0xFF; read 0x0F0 with NUM_CH=4 -> pslverr=1, prdata=0.
REQ-032 Debug halt: DBG_HALT=1, dbg_mode pulsed 10 cycles mid-count -> CNT frozen 10 cycles, resumes from held value; DBG_HALT=0 -> unaffected.
REQ-033 Wrap/reset: CNT_W=8, CMP=0x10, CNT written 0x20 -> counts to 0xFF, wraps to 0, flag at 0x10; sys_rst asserted mid-count -> all registers 0 next cycle.
